proj_fm_minhash: RTL and testbench

//  Downstream consumer of the FM buffer RAM read stream. Takes one DATA_BITS sample per

---
 rtl/proj_minhash_pkg.sv | 30 +++
 rtl/proj_minhash_lane.sv | 48 ++++
 rtl/proj_fm_minhash.sv | 112 +++++++++++
 tb/tb_proj_fm_minhash.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_minhash_pkg.sv
// Shared constants, types and the hash helper for the FM-buffer MinHash block.
package proj_minhash_pkg;

    localparam int MAX_HASHES = 8;

    // Multipliers must stay odd so each hash is a bijection on its lane width.
    localparam logic [15:0] HASH_A [0:MAX_HASHES-1] = '{
        16'h9E37, 16'h85EB, 16'hC2B3, 16'h27D5,
        16'h165B, 16'hD3A1, 16'h4F1D, 16'hA5A5
    };

    localparam logic [15:0] HASH_B [0:MAX_HASHES-1] = '{
        16'h7F4A, 16'h1234, 16'hBEEF, 16'h0F0F,
        16'h3C3C, 16'h5A5A, 16'hC001, 16'h2468
    };

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Unsigned x*a+b at 32 bits. Callers keep only their low lane bits, so the
    // result equals (x*a+b) mod 2^HASH_BITS for any HASH_BITS up to 32.
    function automatic logic [31:0] hash(input logic [31:0] x,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        return (x * a) + b;
    endfunction

endpackage

// File: rtl/proj_minhash_lane.sv
// One signature lane: a linear hash of the sample plus its running-minimum register.
// min_out is the minimum including the current beat, so the top can capture the
// finished signature on the same edge as the last sample.
module proj_minhash_lane
    import proj_minhash_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int HASH_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 beat,
    input  logic                 first,
    input  logic                 clear,
    input  logic [DATA_BITS-1:0] data,
    input  logic [HASH_BITS-1:0] a,
    input  logic [HASH_BITS-1:0] b,
    output logic [HASH_BITS-1:0] min_out
);

    logic [HASH_BITS-1:0] h;
    logic [HASH_BITS-1:0] min_d;
    logic [HASH_BITS-1:0] min_q;

    assign h = HASH_BITS'(hash(32'(data), 32'(a), 32'(b)));

    // First sample of a window overwrites; later samples only lower the minimum.
    always_comb begin
        min_d = min_q;
        if (clear) begin
            min_d = '1;
        end else if (beat) begin
            min_d = (first || (h < min_q)) ? h : min_q;
        end
    end

    // Running-minimum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
        end else begin
            min_q <= min_d;
        end
    end

    assign min_out = min_d;

endmodule

// File: rtl/proj_fm_minhash.sv
// MinHash signature generator fed by the FM buffer RAM read stream.
//
//  state | meaning
//  ACCUM | accepting samples, folding them into the per-lane minima
//  EMIT  | signature held on out_sig until the consumer takes it; input stalled
module proj_fm_minhash
    import proj_minhash_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int NUM_HASHES = 4,
    parameter int HASH_BITS  = 16,
    parameter int WINDOW     = 64
) (
    input  logic                             in_clk,
    input  logic                             in_rst_n,
    input  logic                             in_clear,
    input  logic                             in_valid,
    input  logic [DATA_BITS-1:0]             in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_HASHES*HASH_BITS-1:0]  out_sig
);

    localparam int            CW   = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    state_t                          state_d, state_q;
    logic [CW-1:0]                   count_d, count_q;
    logic                            out_valid_d, out_valid_q;
    logic [NUM_HASHES*HASH_BITS-1:0] out_sig_d, out_sig_q;
    logic [NUM_HASHES*HASH_BITS-1:0] lane_next;

    logic beat;
    logic first;
    logic clear_acc;

    assign in_ready  = (state_q == ACCUM) && !in_clear;
    assign beat      = in_valid && in_ready;
    assign first     = (count_q == '0);
    // A clear while a signature is pending must not touch the lanes' state.
    assign clear_acc = in_clear && (state_q == ACCUM);

    for (genvar g = 0; g < NUM_HASHES; g++) begin : g_lane
        proj_minhash_lane #(
            .DATA_BITS (DATA_BITS),
            .HASH_BITS (HASH_BITS)
        ) u_lane (
            .clk     (in_clk),
            .rst_n   (in_rst_n),
            .beat    (beat),
            .first   (first),
            .clear   (clear_acc),
            .data    (in_data),
            .a       (HASH_BITS'(HASH_A[g])),
            .b       (HASH_BITS'(HASH_B[g])),
            .min_out (lane_next[g*HASH_BITS +: HASH_BITS])
        );
    end

    // Next-state, window counter and output-register update.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sig_d   = out_sig_q;
        unique case (state_q)
            ACCUM: begin
                if (in_clear) begin
                    count_d = '0;
                end else if (beat) begin
                    if (count_q == LAST) begin
                        count_d     = '0;
                        out_valid_d = 1'b1;
                        out_sig_d   = lane_next;
                        state_d     = EMIT;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            EMIT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sig_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sig_q   <= out_sig_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sig   = out_sig_q;

endmodule

// File: tb/tb_proj_fm_minhash.sv
// Bench for proj_fm_minhash: three instances (WINDOW 4, 1, 2) with independent
// stimulus, a signature scoreboard and per-scenario tasks.
module tb_proj_fm_minhash;
    import proj_minhash_pkg::*;

    localparam int NH = 4;
    localparam int HB = 16;
    localparam int SW = NH * HB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    in_clear = '0;
    logic [2:0]    in_valid = '0;
    logic [2:0]    out_ready = '0;
    logic [2:0]    in_ready;
    logic [2:0]    out_valid;
    logic [7:0]    in_data [3];
    logic [SW-1:0] out_sig [3];

    typedef struct {
        int            idx;
        logic [SW-1:0] sig;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] last_sig [3];
    int            win[$];

    always #5 clk = ~clk;

    proj_fm_minhash #(.DATA_BITS(8), .NUM_HASHES(NH), .HASH_BITS(HB), .WINDOW(4)) u_w4 (
        .in_clk(clk), .in_rst_n(rst_n), .in_clear(in_clear[0]), .in_valid(in_valid[0]),
        .in_data(in_data[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sig(out_sig[0]));

    proj_fm_minhash #(.DATA_BITS(8), .NUM_HASHES(NH), .HASH_BITS(HB), .WINDOW(1)) u_w1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_clear(in_clear[1]), .in_valid(in_valid[1]),
        .in_data(in_data[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sig(out_sig[1]));

    proj_fm_minhash #(.DATA_BITS(8), .NUM_HASHES(NH), .HASH_BITS(HB), .WINDOW(2)) u_w2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_clear(in_clear[2]), .in_valid(in_valid[2]),
        .in_data(in_data[2]), .in_ready(in_ready[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sig(out_sig[2]));

    function automatic logic [15:0] model_h(input int i, input int d);
        int p;
        p = d * int'(HASH_A[i]) + int'(HASH_B[i]);
        return 16'(p % 65536);
    endfunction

    function automatic logic [SW-1:0] model_sig(input int d[$]);
        logic [SW-1:0] s;
        logic [15:0]   m;
        logic [15:0]   h;
        s = '0;
        for (int i = 0; i < NH; i++) begin
            m = 16'hFFFF;
            for (int k = 0; k < d.size(); k++) begin
                h = model_h(i, d[k]);
                if (h < m) m = h;
            end
            s[i*HB +: HB] = m;
        end
        return s;
    endfunction

    // Scoreboard: every completed output handshake pops one expected signature.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && out_valid[i] && out_ready[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected inst=%0d got=%h expected=none", i, out_sig[i]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.idx != i || out_sig[i] !== mon_e.sig) begin
                        errors++;
                        $display("FAIL sb_sig inst=%0d got=%h expected inst=%0d sig=%h",
                                 i, out_sig[i], mon_e.idx, mon_e.sig);
                    end
                end
                last_sig[i] = out_sig[i];
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready[idx];
            @(posedge clk);
            #1;
        end
        in_valid[idx] = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout inst=%0d data=%h got in_ready=0 expected 1 within 50 cycles", idx, d);
        end
    endtask

    task automatic send_win(input int idx);
        exp_t e;
        e.idx = idx;
        e.sig = model_sig(win);
        sb.push_back(e);
        for (int k = 0; k < win.size(); k++) begin
            if (k == win.size() - 1 && win.size() > 1) begin
                checks++;
                if (out_valid[idx] !== 1'b0) begin
                    errors++;
                    $display("FAIL early_valid inst=%0d got=%b expected=0", idx, out_valid[idx]);
                end
            end
            send(idx, 8'(win[k]));
        end
        checks++;
        if (out_valid[idx] !== 1'b1) begin
            errors++;
            $display("FAIL emit_latency inst=%0d got out_valid=%b expected=1", idx, out_valid[idx]);
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 30 && sb.size() != 0; n++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || out_sig[i] !== '0) begin
                errors++;
                $display("FAIL reset_vals inst=%0d got rdy=%b vld=%b sig=%h expected 1 0 0",
                         i, in_ready[i], out_valid[i], out_sig[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zeros();
        logic [SW-1:0] exp_sig;
        exp_t          e;
        exp_sig = {HASH_B[3], HASH_B[2], HASH_B[1], HASH_B[0]};
        out_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) send(0, 8'h00);
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL zeros_early got out_valid=%b expected=0", out_valid[0]);
        end
        e.idx = 0;
        e.sig = exp_sig;
        sb.push_back(e);
        send(0, 8'h00);
        checks++;
        if (out_valid[0] !== 1'b1 || out_sig[0] !== exp_sig) begin
            errors++;
            $display("FAIL zeros_sig got vld=%b sig=%h expected 1 %h", out_valid[0], out_sig[0], exp_sig);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL zeros_pulse got out_valid=%b expected=0", out_valid[0]);
        end
        wait_drain();
    endtask

    task automatic test_window1();
        out_ready[1] = 1'b1;
        win = {8'h01};
        send_win(1);
        win = {8'hFF};
        send_win(1);
        win = {8'h80};
        send_win(1);
        wait_drain();
    endtask

    task automatic test_order();
        logic [SW-1:0] s1;
        out_ready[0] = 1'b1;
        win = {3, 200, 17, 90};
        send_win(0);
        wait_drain();
        s1 = last_sig[0];
        win = {90, 17, 200, 3};
        send_win(0);
        wait_drain();
        checks++;
        if (last_sig[0] !== s1) begin
            errors++;
            $display("FAIL order_invariant got=%h expected=%h", last_sig[0], s1);
        end
    endtask

    task automatic test_back_to_back();
        out_ready[0] = 1'b1;
        win = {250, 1, 128, 64};
        send_win(0);
        win = {7, 7, 7, 7};
        send_win(0);
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] held;
        out_ready[2] = 1'b0;
        win = {5, 77};
        send_win(2);
        held = out_sig[2];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_sig[2] !== held || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got sig=%h rdy=%b vld=%b expected %h 0 1",
                         c, out_sig[2], in_ready[2], out_valid[2], held);
            end
        end
        @(posedge clk);
        #1;
        out_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b expected 0 1", out_valid[2], in_ready[2]);
        end
        wait_drain();
    endtask

    task automatic test_clear();
        out_ready[0] = 1'b1;
        send(0, 8'h00);
        send(0, 8'h00);
        in_clear[0] = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h00;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready got=%b expected=0", in_ready[0]);
        end
        @(posedge clk);
        #1;
        in_clear[0] = 1'b0;
        in_valid[0] = 1'b0;
        win = {5, 6, 7, 8};
        send_win(0);
        wait_drain();
        // A clear while the signature waits must not lose it.
        out_ready[0] = 1'b0;
        win = {9, 10, 11, 12};
        send_win(0);
        in_clear[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL clear_emit got out_valid=%b expected=1", out_valid[0]);
        end
        in_clear[0]  = 1'b0;
        out_ready[0] = 1'b1;
        wait_drain();
    endtask

    task automatic test_async_reset();
        out_ready[0] = 1'b1;
        win = {1, 2, 3, 4};
        send_win(0);
        wait_drain();
        send(0, 8'h00);
        send(0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || out_sig[0] !== '0) begin
            errors++;
            $display("FAIL async_reset got vld=%b sig=%h expected 0 0", out_valid[0], out_sig[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        win = {40, 41, 42, 43};
        send_win(0);
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_data[i]  = 8'h00;
            last_sig[i] = '0;
        end
        test_reset();
        test_zeros();
        test_window1();
        test_order();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time limit expected completion");
        $fatal(1, "watchdog");
    end

endmodule
